// File: rtl/alu_op_sequencer_if.sv
// Bundle of requester, ALU and response signals around alu_op_sequencer.
// master = requesters/consumer/ALU environment, slave = the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned W = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [3:0]   req0_sel;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [3:0]   req1_sel;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         alu_en;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;
  logic         alu_flag;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_y;
  logic         rsp_flag;
  logic         busy;

  modport master (
    output req0_valid, req0_sel, req0_a, req0_b,
    output req1_valid, req1_sel, req1_a, req1_b,
    output alu_y, alu_flag, rsp_ready,
    input  req0_ready, req1_ready, alu_en, alu_sel, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_y, rsp_flag, busy
  );

  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b,
    input  req1_valid, req1_sel, req1_a, req1_b,
    input  alu_y, alu_flag, rsp_ready,
    output req0_ready, req1_ready, alu_en, alu_sel, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_y, rsp_flag, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Round-robin sharing of one combinational ALU between two requesters; each accepted op drives
// the ALU for ALU_LAT cycles and returns the captured result on a tagged valid/ready channel.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned W       = 4
) (
  input logic              clk,
  input logic              rst,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [3:0] LatInit = 4'(ALU_LAT - 1);

  state_e       state_q, state_d;
  logic         rr_ptr_q, rr_ptr_d;
  logic [3:0]   lat_cnt_q, lat_cnt_d;
  logic         id_q, id_d;
  logic [3:0]   alu_sel_q, alu_sel_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [W-1:0] rsp_y_q, rsp_y_d;
  logic         rsp_flag_q, rsp_flag_d;
  logic         rsp_id_q, rsp_id_d;

  logic any_valid;
  logic grant_id;
  logic accept;

  // Ready is masked by rst so nothing appears accepted during a reset cycle.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid & bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
    accept    = ~rst & (state_q == StIdle) & any_valid;
  end

  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept & grant_id;
  assign bus.alu_en     = (state_q == StIssue);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.busy       = (state_q != StIdle);
  assign bus.alu_sel    = alu_sel_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign bus.rsp_id     = rsp_id_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lat_cnt_d  = lat_cnt_q;
    id_d       = id_q;
    alu_sel_d  = alu_sel_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_y_d    = rsp_y_q;
    rsp_flag_d = rsp_flag_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_sel_d = grant_id ? bus.req1_sel : bus.req0_sel;
          alu_a_d   = grant_id ? bus.req1_a : bus.req0_a;
          alu_b_d   = grant_id ? bus.req1_b : bus.req0_b;
          id_d      = grant_id;
          rr_ptr_d  = ~grant_id;
          lat_cnt_d = LatInit;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (lat_cnt_q == 4'd0) begin
          rsp_y_d    = bus.alu_y;
          rsp_flag_d = bus.alu_flag;
          rsp_id_d   = id_q;
          state_d    = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      lat_cnt_q  <= 4'd0;
      id_q       <= 1'b0;
      alu_sel_q  <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_y_q    <= '0;
      rsp_flag_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lat_cnt_q  <= lat_cnt_d;
      id_q       <= id_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_y_q    <= rsp_y_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

endmodule
